// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller slice.
//   - SDRAM command encodings {cs_n, ras_n, cas_n, we_n}
//   - one-hot arbiter state encoding
//   - default address / bank widths
package sdram_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int BA_W_DEF   = 2;

    localparam logic [3:0] CMD_NOP       = 4'b0111;
    localparam logic [3:0] CMD_PRECHARGE = 4'b0010;
    localparam logic [3:0] CMD_REFRESH   = 4'b0001;
    localparam logic [3:0] CMD_MODE      = 4'b0000;
    localparam logic [3:0] CMD_ACTIVE    = 4'b0011;
    localparam logic [3:0] CMD_WRITE     = 4'b0100;
    localparam logic [3:0] CMD_READ      = 4'b0101;

    typedef enum logic [4:0] {
        ST_INIT    = 5'b00001,
        ST_ARBIT   = 5'b00010,
        ST_REFRESH = 5'b00100,
        ST_WRITE   = 5'b01000,
        ST_READ    = 5'b10000
    } state_t;

endpackage

// File: rtl/sdram_cmd_mux.sv
// Command-bus multiplexer for the SDRAM arbiter. Purely combinational:
// routes the owning sequencer's cmd/addr/ba to the pins according to the
// one-hot arbiter state; drives NOP/0/0 while arbitrating.
// Ports:
//   state_i                          one-hot arbiter state
//   init_*_i / refresh_cmd_i /
//   wr_*_i / rd_*_i                  source buses
//   cmd_o / addr_o / ba_o            selected bus to the pin drivers
module sdram_cmd_mux
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF
) (
    input  logic [4:0]        state_i,
    input  logic [3:0]        init_cmd_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [BA_W-1:0]   init_ba_i,
    input  logic [3:0]        refresh_cmd_i,
    input  logic [3:0]        wr_cmd_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [BA_W-1:0]   wr_ba_i,
    input  logic [3:0]        rd_cmd_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [BA_W-1:0]   rd_ba_i,
    output logic [3:0]        cmd_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [BA_W-1:0]   ba_o
);

    always_comb begin
        cmd_o  = CMD_NOP;
        addr_o = '0;
        ba_o   = '0;
        case (state_i)
            ST_INIT: begin
                cmd_o  = init_cmd_i;
                addr_o = init_addr_i;
                ba_o   = init_ba_i;
            end
            // Auto-refresh needs no address; keep addr/ba parked at zero.
            ST_REFRESH: cmd_o = refresh_cmd_i;
            ST_WRITE: begin
                cmd_o  = wr_cmd_i;
                addr_o = wr_addr_i;
                ba_o   = wr_ba_i;
            end
            ST_READ: begin
                cmd_o  = rd_cmd_i;
                addr_o = rd_addr_i;
                ba_o   = rd_ba_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sdram_arbit.sv
// Central SDRAM arbiter. Holds the command bus for the init sequencer until
// init_end, then grants it to refresh, write or read via req/ack/end
// handshakes. No pre-emption: an owner keeps the bus until its own *_end.
// Acks are decoded from the registered one-hot state (1-cycle grant latency).
// Ports:
//   sysclk_100M, rst_n (async, active-low)
//   init_end, init_cmd/addr/ba       init sequencer
//   refresh_req/ack/end/cmd          refresh sequencer
//   wr_req/ack/end/cmd/addr/ba       write sequencer
//   rd_req/ack/end/cmd/addr/ba       read sequencer
//   sdram_cmd/addr/ba                bus to the pin drivers
// Build option: define SDRAM_ARBIT_RR_EN for round-robin between write and
// read; otherwise write has fixed priority over read. Refresh always wins.
module sdram_arbit
    import sdram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int BA_W   = BA_W_DEF
) (
    input  logic              sysclk_100M,
    input  logic              rst_n,
    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [BA_W-1:0]   init_ba,
    input  logic              refresh_req,
    output logic              refresh_ack,
    input  logic              refresh_end,
    input  logic [3:0]        refresh_cmd,
    input  logic              wr_req,
    output logic              wr_ack,
    input  logic              wr_end,
    input  logic [3:0]        wr_cmd,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BA_W-1:0]   wr_ba,
    input  logic              rd_req,
    output logic              rd_ack,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [BA_W-1:0]   rd_ba,
    output logic [3:0]        sdram_cmd,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [BA_W-1:0]   sdram_ba
);

    state_t state_q;
    state_t grant_d;    // owner to move to if the FSM is in ARBIT
    logic   wr_wins;

`ifdef SDRAM_ARBIT_RR_EN
    logic last_rd_q;
    // On a wr/rd tie, write wins only if read was served last.
    assign wr_wins = wr_req && (!rd_req || last_rd_q);
`else
    assign wr_wins = wr_req;
`endif

    always_comb begin
        grant_d = ST_ARBIT;
        if (refresh_req)  grant_d = ST_REFRESH;
        else if (wr_wins) grant_d = ST_WRITE;
        else if (rd_req)  grant_d = ST_READ;
    end

    always_ff @(posedge sysclk_100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
`ifdef SDRAM_ARBIT_RR_EN
            last_rd_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_INIT:    if (init_end)    state_q <= ST_ARBIT;
                ST_ARBIT: begin
                    state_q <= grant_d;
`ifdef SDRAM_ARBIT_RR_EN
                    if (grant_d == ST_READ)       last_rd_q <= 1'b1;
                    else if (grant_d == ST_WRITE) last_rd_q <= 1'b0;
`endif
                end
                // Only the owner's end pulse releases the bus.
                ST_REFRESH: if (refresh_end) state_q <= ST_ARBIT;
                ST_WRITE:   if (wr_end)      state_q <= ST_ARBIT;
                ST_READ:    if (rd_end)      state_q <= ST_ARBIT;
                default:                     state_q <= ST_INIT;
            endcase
        end
    end

    assign refresh_ack = (state_q == ST_REFRESH);
    assign wr_ack      = (state_q == ST_WRITE);
    assign rd_ack      = (state_q == ST_READ);

    sdram_cmd_mux #(
        .ADDR_W (ADDR_W),
        .BA_W   (BA_W)
    ) u_cmd_mux (
        .state_i       (state_q),
        .init_cmd_i    (init_cmd),
        .init_addr_i   (init_addr),
        .init_ba_i     (init_ba),
        .refresh_cmd_i (refresh_cmd),
        .wr_cmd_i      (wr_cmd),
        .wr_addr_i     (wr_addr),
        .wr_ba_i       (wr_ba),
        .rd_cmd_i      (rd_cmd),
        .rd_addr_i     (rd_addr),
        .rd_ba_i       (rd_ba),
        .cmd_o         (sdram_cmd),
        .addr_o        (sdram_addr),
        .ba_o          (sdram_ba)
    );

endmodule

// File: tb/tb_sdram_arbit.sv
// Testbench for sdram_arbit: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a behavioural
// owner model. Honours SDRAM_ARBIT_RR_EN when defined.
module tb_sdram_arbit;

    localparam int AW = 13;
    localparam int BW = 2;

    localparam int O_INIT = 0, O_ARB = 1, O_REF = 2, O_WR = 3, O_RD = 4;

    logic          sysclk = 1'b0;
    logic          rst_n = 1'b0;
    logic          init_end = 1'b0;
    logic [3:0]    init_cmd = 4'b0010;
    logic [AW-1:0] init_addr = '0;
    logic [BW-1:0] init_ba = '0;
    logic          refresh_req = 1'b0, refresh_end = 1'b0;
    logic [3:0]    refresh_cmd = 4'b0001;
    logic          wr_req = 1'b0, wr_end = 1'b0;
    logic [3:0]    wr_cmd = 4'b0100;
    logic [AW-1:0] wr_addr = '0;
    logic [BW-1:0] wr_ba = '0;
    logic          rd_req = 1'b0, rd_end = 1'b0;
    logic [3:0]    rd_cmd = 4'b0101;
    logic [AW-1:0] rd_addr = '0;
    logic [BW-1:0] rd_ba = '0;
    logic          refresh_ack, wr_ack, rd_ack;
    logic [3:0]    sdram_cmd;
    logic [AW-1:0] sdram_addr;
    logic [BW-1:0] sdram_ba;

    int n_chk = 0;
    int n_fail = 0;

    always #5 sysclk = ~sysclk;

    sdram_arbit #(.ADDR_W(AW), .BA_W(BW)) dut (
        .sysclk_100M (sysclk),      .rst_n       (rst_n),
        .init_end    (init_end),    .init_cmd    (init_cmd),
        .init_addr   (init_addr),   .init_ba     (init_ba),
        .refresh_req (refresh_req), .refresh_ack (refresh_ack),
        .refresh_end (refresh_end), .refresh_cmd (refresh_cmd),
        .wr_req      (wr_req),      .wr_ack      (wr_ack),
        .wr_end      (wr_end),      .wr_cmd      (wr_cmd),
        .wr_addr     (wr_addr),     .wr_ba       (wr_ba),
        .rd_req      (rd_req),      .rd_ack      (rd_ack),
        .rd_end      (rd_end),      .rd_cmd      (rd_cmd),
        .rd_addr     (rd_addr),     .rd_ba       (rd_ba),
        .sdram_cmd   (sdram_cmd),   .sdram_addr  (sdram_addr),
        .sdram_ba    (sdram_ba)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: who owns the bus ----------------
    int   m_own = O_INIT;
    logic m_last_rd = 1'b0;

    always @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            m_own = O_INIT;
            m_last_rd = 1'b0;
        end else if (m_own == O_INIT) begin
            if (init_end) m_own = O_ARB;
        end else if (m_own == O_ARB) begin
            if (refresh_req) m_own = O_REF;
            else if (wr_req && rd_req) begin
`ifdef SDRAM_ARBIT_RR_EN
                m_own = m_last_rd ? O_WR : O_RD;
`else
                m_own = O_WR;
`endif
            end
            else if (wr_req) m_own = O_WR;
            else if (rd_req) m_own = O_RD;
            if (m_own == O_WR) m_last_rd = 1'b0;
            if (m_own == O_RD) m_last_rd = 1'b1;
        end else if ((m_own == O_REF && refresh_end) ||
                     (m_own == O_WR && wr_end) ||
                     (m_own == O_RD && rd_end)) begin
            m_own = O_ARB;
        end
    end

    // Every cycle, 1 time unit after the edge.
    always @(posedge sysclk) begin
        logic [2:0]    e_ack;
        logic [3:0]    e_cmd;
        logic [AW-1:0] e_addr;
        logic [BW-1:0] e_ba;
        #1;
        e_ack = {m_own == O_REF, m_own == O_WR, m_own == O_RD};
        e_cmd = 4'b0111; e_addr = '0; e_ba = '0;
        if (m_own == O_INIT) begin e_cmd = init_cmd; e_addr = init_addr; e_ba = init_ba; end
        if (m_own == O_REF)  e_cmd = refresh_cmd;
        if (m_own == O_WR)   begin e_cmd = wr_cmd; e_addr = wr_addr; e_ba = wr_ba; end
        if (m_own == O_RD)   begin e_cmd = rd_cmd; e_addr = rd_addr; e_ba = rd_ba; end
        chk("model_acks", {29'd0, refresh_ack, wr_ack, rd_ack}, {29'd0, e_ack});
        chk("model_cmd", {28'd0, sdram_cmd}, {28'd0, e_cmd});
        chk("model_addr", {19'd0, sdram_addr}, {19'd0, e_addr});
        chk("model_ba", {30'd0, sdram_ba}, {30'd0, e_ba});
    end

    task automatic tick();
        @(posedge sysclk);
        #2;
    endtask

    function automatic logic [31:0] acks();
        return {29'd0, refresh_ack, wr_ack, rd_ack};
    endfunction

    task automatic set_ends(input logic [2:0] who);
        refresh_end = who[2];
        wr_end      = who[1];
        rd_end      = who[0];
    endtask

    logic [2:0] first_g, second_g, got;

    initial begin
        // Reset: init bus passes straight through, no acks.
        tick(); tick();
        chk("rst_acks", acks(), 32'd0);
        chk("rst_cmd", {28'd0, sdram_cmd}, 32'h2);
        rst_n = 1'b1;

        // Init phase: init_end low for 50 cycles.
        for (int i = 0; i < 50; i++) begin
            tick();
            init_cmd  = 4'($urandom);
            init_addr = AW'($urandom);
            init_ba   = BW'($urandom);
        end
        chk("init_acks", acks(), 32'd0);
        init_end = 1'b1;
        tick();
        chk("arbit_nop", {28'd0, sdram_cmd}, 32'h7);
        chk("arbit_addr", {19'd0, sdram_addr}, 32'd0);

        // Three simultaneous requests: refresh first.
        refresh_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        wr_addr = 13'h0123; rd_addr = 13'h1abc; wr_ba = 2'd1; rd_ba = 2'd2;
        tick();
        chk("ref_ack", acks(), 32'b100);
        chk("ref_cmd", {28'd0, sdram_cmd}, 32'h1);
        refresh_req = 1'b0;
        set_ends(3'b011);              // non-owner ends are ignored
        tick();
        chk("ignore_end", acks(), 32'b100);
        set_ends(3'b000);
        tick();
        set_ends(3'b100);
        tick();
        chk("nop_after_ref", {28'd0, sdram_cmd}, 32'h7);
        chk("acks_after_ref", acks(), 32'd0);
        set_ends(3'b000);
`ifdef SDRAM_ARBIT_RR_EN
        first_g = 3'b001; second_g = 3'b010;
`else
        first_g = 3'b010; second_g = 3'b001;
`endif
        tick();
        chk("first_grant", acks(), {29'd0, first_g});
        if (first_g == 3'b010) wr_req = 1'b0; else rd_req = 1'b0;
        tick();
        set_ends(first_g);
        tick();
        chk("nop_between", acks(), 32'd0);
        set_ends(3'b000);
        tick();
        chk("second_grant", acks(), {29'd0, second_g});
        chk("second_addr", {19'd0, sdram_addr}, (second_g == 3'b001) ? 32'h1abc : 32'h0123);
        wr_req = 1'b0; rd_req = 1'b0;
        set_ends(second_g);
        tick();
        set_ends(3'b000);

        // 20-cycle write, refresh arrives at cycle 3 and must wait.
        wr_req = 1'b1;
        tick();
        chk("long_wr_grant", acks(), 32'b010);
        wr_req = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (c == 3) refresh_req = 1'b1;
            tick();
            chk("long_wr_hold", acks(), 32'b010);
        end
        wr_end = 1'b1;
        tick();
        chk("long_wr_release", acks(), 32'd0);
        wr_end = 1'b0;
        tick();
        chk("ref_after_wr", acks(), 32'b100);
        refresh_req = 1'b0;
        refresh_end = 1'b1;
        tick();
        refresh_end = 1'b0;

        // Continuous wr+rd requests.
        wr_req = 1'b1; rd_req = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            got = {refresh_ack, wr_ack, rd_ack};
`ifdef SDRAM_ARBIT_RR_EN
            chk("rr_grant", {29'd0, got}, (i % 2 == 0) ? 32'b001 : 32'b010);
`else
            chk("fixed_grant", {29'd0, got}, 32'b010);
`endif
            set_ends(got);
            tick();
            set_ends(3'b000);
        end
        wr_req = 1'b0; rd_req = 1'b0;

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 2000; i++) begin
            refresh_req = ($urandom_range(0, 7) == 0);
            wr_req      = ($urandom_range(0, 2) == 0);
            rd_req      = ($urandom_range(0, 2) == 0);
            refresh_end = ($urandom_range(0, 3) == 0);
            wr_end      = ($urandom_range(0, 3) == 0);
            rd_end      = ($urandom_range(0, 3) == 0);
            refresh_cmd = 4'($urandom);
            wr_cmd = 4'($urandom); wr_addr = AW'($urandom); wr_ba = BW'($urandom);
            rd_cmd = 4'($urandom); rd_addr = AW'($urandom); rd_ba = BW'($urandom);
            tick();
        end

        // Return to ARBIT, then reset in the middle of a read.
        refresh_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
        set_ends(3'b111);
        tick();
        set_ends(3'b000);
        tick();
        rd_req = 1'b1;
        init_cmd = 4'b1010;
        tick();
        chk("pre_rst_rd", acks(), 32'b001);
        rd_req = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_acks", acks(), 32'd0);
        chk("async_rst_cmd", {28'd0, sdram_cmd}, 32'ha);
        init_end = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        chk("reinit_acks", acks(), 32'd0);
        chk("reinit_cmd", {28'd0, sdram_cmd}, 32'ha);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
